fetch_ir_unit: RTL and testbench



---
 rtl/fetch_ir_unit.sv | 108 ++++++++++
 tb/tb_fetch_ir_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ir_unit.sv
// Instruction-fetch front end: PC, IR, variable-latency imem handshake and
// IR field/immediate decode for the multicycle CPU.
module fetch_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic        ExtSel,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [5:0]  opCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [31:0] imm_ext,
  output logic        stall,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, READY, LOADED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] next_pc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ibuf_q  <= ibuf_d;
    end
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign imm_ext  = ExtSel ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0000, ir_q[15:0]};

  // jr target masks the low two bits of rs_data to keep the PC word-aligned
  always_comb begin
    next_pc = pc_plus4;
    unique case (PCSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
      2'b10: next_pc = rs_data & 32'hFFFF_FFFC;
      2'b11: next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ibuf_d  = ibuf_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ibuf_d  = imem_rdata;
          state_d = READY;
        end
      end
      READY: begin
        if (IRWre) begin
          ir_d    = ibuf_q;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (PCWre) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign stall     = (state_q == IDLE) || (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opCode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign sa        = ir_q[10:6];
  assign halted    = (ir_q[31:26] == 6'b111111);

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Scoreboard bench for fetch_ir_unit: a behavioural imem with configurable ack
// delay, directed PC/IR sequences, and a monitor checking each fetch start.
module tb_fetch_ir_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCWre = 1'b0, IRWre = 1'b0, ExtSel = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] rs_data = '0, imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req, stall, halted;
  logic [31:0] imem_addr, pc, pc_plus4, ir, imm_ext;
  logic [5:0]  opCode;
  logic [4:0]  rs, rt, rd, sa;

  typedef struct { logic [31:0] addr; logic [31:0] ir; } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;

  fetch_ir_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc),
    .ExtSel(ExtSel), .rs_data(rs_data), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .opCode(opCode), .rs(rs),
    .rt(rt), .rd(rd), .sa(sa), .imm_ext(imm_ext), .stall(stall),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0022_1800;
      32'h0000_0004: mem_word = 32'h0800_0004;
      32'h0000_0010: mem_word = 32'h1000_FFFE;
      32'h0000_000C: mem_word = 32'h2022_0005;
      32'h0000_0044: mem_word = 32'h0043_2020;
      32'h1000_0004: mem_word = 32'h0800_0010;
      32'h1000_0040: mem_word = 32'hFC00_0000;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction memory: acks after ack_delay waiting cycles of a held request
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge CLK);
      imem_ack = 1'b0;
      if (RST && imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every new fetch request is compared against the next expected entry
  initial begin
    logic prev_req = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_req = 1'b0;
      end else begin
        if (imem_req && !prev_req) begin
          if (q.size() == 0) begin
            chk("unexpected_fetch_addr", imem_addr, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("fetch_addr", imem_addr, e.addr);
            chk("fetch_pc", pc, e.addr);
            chk("fetch_ir_held", ir, e.ir);
          end
        end
        prev_req = imem_req;
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (stall && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (stall) chk(nm, 32'(stall), 32'd0);
  endtask

  task automatic load_ir();
    IRWre = 1'b1;
    @(negedge CLK);
    IRWre = 1'b0;
  endtask

  task automatic step_pc(input logic [1:0] src, input logic [31:0] rsd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_ir);
    exp_t e;
    e.addr = exp_addr;
    e.ir   = exp_ir;
    q.push_back(e);
    PCSrc   = src;
    rs_data = rsd;
    PCWre   = 1'b1;
    @(negedge CLK);
    PCWre   = 1'b0;
  endtask

  initial begin
    exp_t e;
    int n;
    logic [31:0] pc_hold;

    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_ir", ir, 32'h0);
    chk("rst_imm_ext", imm_ext, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);

    @(negedge CLK);
    e.addr = 32'h0; e.ir = 32'h0;
    q.push_back(e);
    RST = 1'b1;
    @(negedge CLK);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_stall", 32'(stall), 32'd1);
    @(negedge CLK);
    chk("first_ready_stall", 32'(stall), 32'd0);
    load_ir();
    chk("ir0", ir, 32'h0022_1800);
    chk("opcode0", 32'(opCode), 32'd0);
    chk("rs0", 32'(rs), 32'd1);
    chk("rt0", 32'(rt), 32'd2);
    chk("rd0", 32'(rd), 32'd3);
    chk("sa0", 32'(sa), 32'd0);
    chk("imm0", imm_ext, 32'h0000_1800);

    step_pc(2'b00, '0, 32'h4, 32'h0022_1800);
    wait_ready("timeout_fetch4");
    load_ir();
    chk("ir4", ir, 32'h0800_0004);

    step_pc(2'b11, '0, 32'h10, 32'h0800_0004);
    wait_ready("timeout_fetch10");
    load_ir();
    chk("ir10", ir, 32'h1000_FFFE);
    ExtSel = 1'b1; #1;
    chk("imm_sext", imm_ext, 32'hFFFF_FFFE);
    ExtSel = 1'b0; #1;
    chk("imm_zext", imm_ext, 32'h0000_FFFE);
    ExtSel = 1'b1;

    ack_delay = 3;
    step_pc(2'b01, '0, 32'h0C, 32'h1000_FFFE);
    chk("branch_pc", pc, 32'h0000_000C);
    n = 0;
    while (stall && n < 30) begin
      if (imem_req) n++;
      IRWre = 1'b1;
      @(negedge CLK);
    end
    IRWre = 1'b0;
    chk("slow_fetch_cycles", 32'(n), 32'd4);
    chk("ir_during_fetch", ir, 32'h1000_FFFE);
    load_ir();
    chk("ir0c", ir, 32'h2022_0005);
    chk("opcode0c", 32'(opCode), 32'd8);
    chk("imm0c", imm_ext, 32'h0000_0005);

    ack_delay = 0;
    step_pc(2'b10, 32'h0000_0047, 32'h44, 32'h2022_0005);
    wait_ready("timeout_fetch44");
    load_ir();
    chk("ir44", ir, 32'h0043_2020);

    step_pc(2'b10, 32'h1000_0004, 32'h1000_0004, 32'h0043_2020);
    wait_ready("timeout_fetch_hi");
    load_ir();
    chk("ir_hi", ir, 32'h0800_0010);

    step_pc(2'b11, '0, 32'h1000_0040, 32'h0800_0010);
    wait_ready("timeout_fetch_halt");
    chk("halted_before_load", 32'(halted), 32'd0);
    load_ir();
    chk("halted", 32'(halted), 32'd1);
    chk("halt_opcode", 32'(opCode), 32'h3F);

    pc_hold = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", pc, pc_hold);
    end

    step_pc(2'b00, '0, 32'h1000_0044, 32'hFC00_0000);
    #2;
    chk("ack_pending", 32'(imem_ack), 32'd1);
    RST = 1'b0;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_stall", 32'(stall), 32'd1);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    e.addr = 32'h0; e.ir = 32'h0;
    q.push_back(e);
    RST = 1'b1;
    @(negedge CLK);
    wait_ready("timeout_post_reset");
    load_ir();
    chk("ir_post_reset", ir, 32'h0022_1800);

    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("scoreboard_left", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
